hwpe_stream_tcdm_store_addrgen: RTL and testbench

HWPE_STREAM_TCDM_STORE_ADDRGEN -- requirements
Module: hwpe_stream_tcdm_store_addrgen

---
 rtl/hwpe_stream_tcdm_store_addrgen.sv | 107 ++++++++++
 tb/tb_hwpe_stream_tcdm_store_addrgen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_store_addrgen.sv
// hwpe_stream_tcdm_store_addrgen
//   Turns an incoming data stream into a sequence of TCDM write requests.
//   Each accepted start launches one job of num_words_i words. Word n goes to
//   base_addr_i + n*stride_i, with the address wrapping modulo 2^32. The data
//   path is a zero-latency combinational pass-through: the stream valid drives
//   the TCDM request, and the TCDM grant drives the stream ready.
//
// Ports
//   clk_i, rst_ni           rising-edge clock, synchronous active-low reset
//   clear_i                 synchronous soft clear (same effect as reset)
//   start_i                 launch a job (sampled in IDLE only)
//   base_addr_i             byte address of the first word
//   stride_i                unsigned byte increment between words
//   num_words_i             words in the job (0 -> straight to DONE)
//   busy_o                  high while the job is running
//   done_o                  one-cycle pulse at job end
//   stream_*                sink side of the data stream
//   tcdm_*                  TCDM write master
module hwpe_stream_tcdm_store_addrgen #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [31:0]             base_addr_i,
    input  logic [CNT_WIDTH-1:0]    stride_i,
    input  logic [CNT_WIDTH-1:0]    num_words_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    stream_valid_i,
    output logic                    stream_ready_o,
    input  logic [DATA_WIDTH-1:0]   stream_data_i,
    input  logic [DATA_WIDTH/8-1:0] stream_strb_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [31:0]             tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [31:0]          addr;
    logic [CNT_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0] num_q;
    logic [CNT_WIDTH-1:0] cnt;

    logic run;
    logic hs;
    logic last;

    assign run  = (state == RUN);
    // The grant only qualifies the transfer. It never feeds back into the request.
    assign hs   = run & stream_valid_i & tcdm_gnt_i;
    // num_q is never 0 in RUN, because a zero-length job skips RUN entirely.
    assign last = (cnt == num_q - CNT_WIDTH'(1));

    assign tcdm_req_o     = run & stream_valid_i;
    assign stream_ready_o = run & tcdm_gnt_i;
    assign tcdm_add_o     = addr;
    assign tcdm_wen_o     = 1'b0;
    assign tcdm_be_o      = stream_strb_i;
    assign tcdm_data_o    = stream_data_i;
    assign busy_o         = run;
    assign done_o         = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state    <= IDLE;
            addr     <= '0;
            stride_q <= '0;
            num_q    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (num_words_i != '0) begin
                            addr     <= base_addr_i;
                            stride_q <= stride_i;
                            num_q    <= num_words_i;
                            cnt      <= '0;
                            state    <= RUN;
                        end else begin
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        addr <= addr + 32'(stride_q);
                        cnt  <= cnt + CNT_WIDTH'(1);
                        if (last)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_store_addrgen.sv
// Directed bench for hwpe_stream_tcdm_store_addrgen: a table of jobs with
// hand-computed addresses and timing, plus hand-written clear/reset sequences.
module tb_hwpe_stream_tcdm_store_addrgen;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] stride_i = '0;
    logic [15:0] num_words_i = '0;
    logic        busy_o, done_o;
    logic        stream_valid_i = 1'b0;
    logic        stream_ready_o;
    logic [31:0] stream_data_i = '0;
    logic [3:0]  stream_strb_i = '0;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i = 1'b0;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hwpe_stream_tcdm_store_addrgen #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .num_words_i(num_words_i),
        .busy_o(busy_o), .done_o(done_o),
        .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o),
        .stream_data_i(stream_data_i), .stream_strb_i(stream_strb_i),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o)
    );

    // mode 0: valid and gnt always high
    // mode 1: gnt high only on odd cycles
    // mode 2: valid high only on odd cycles
    typedef struct {
        logic [31:0] base;
        logic [15:0] stride;
        logic [15:0] num;
        int          mode;
        bit          mid_start;
        logic [31:0] exp_addr [4];
        int          exp_hs;
        int          exp_done;   // cycle index (after the start edge) of the done pulse
    } job_t;

    job_t jobs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input job_t j, input int c, input int k);
        stream_valid_i = (j.mode == 2) ? c[0] : 1'b1;
        tcdm_gnt_i     = (j.mode == 1) ? c[0] : 1'b1;
        stream_data_i  = 32'hA500_0000 + 32'(k);
        stream_strb_i  = 4'b0001 << (k % 4);
        start_i        = j.mid_start && (c == 1);
        if (start_i) begin
            base_addr_i = 32'hDEAD_0000;
            stride_i    = 16'd64;
            num_words_i = 16'd2;
        end
    endtask

    // Called right after a posedge (+1). Returns just after a posedge (+1).
    task automatic run_job(input job_t j, input string tag);
        int k;
        k = 0;
        start_i        = 1'b1;
        base_addr_i    = j.base;
        stride_i       = j.stride;
        num_words_i    = j.num;
        stream_valid_i = 1'b1;
        tcdm_gnt_i     = 1'b1;
        @(negedge clk_i);
        // Outside RUN the request stays low even with valid and gnt high.
        chk({tag, " idle_req"}, 32'(tcdm_req_o), 32'd0);
        chk({tag, " idle_ready"}, 32'(stream_ready_o), 32'd0);
        @(posedge clk_i); #1;
        drive_cycle(j, 0, k);
        for (int c = 0; c <= j.exp_done + 1; c++) begin
            @(negedge clk_i);
            chk({tag, " busy"}, 32'(busy_o), 32'(c < j.exp_done));
            chk({tag, " done"}, 32'(done_o), 32'(c == j.exp_done));
            chk({tag, " req"}, 32'(tcdm_req_o), 32'((c < j.exp_done) && stream_valid_i));
            chk({tag, " ready"}, 32'(stream_ready_o), 32'((c < j.exp_done) && tcdm_gnt_i));
            chk({tag, " wen"}, 32'(tcdm_wen_o), 32'd0);
            if (tcdm_req_o && k < 4) begin
                chk({tag, " add"}, tcdm_add_o, j.exp_addr[k]);
                chk({tag, " data"}, tcdm_data_o, 32'hA500_0000 + 32'(k));
                chk({tag, " be"}, 32'(tcdm_be_o), 32'(4'b0001 << (k % 4)));
            end
            if (tcdm_req_o && tcdm_gnt_i) k++;
            @(posedge clk_i); #1;
            drive_cycle(j, c + 1, k);
        end
        chk({tag, " handshakes"}, 32'(k), 32'(j.exp_hs));
        start_i = 1'b0;
    endtask

    initial begin
        jobs[0] = '{32'h0000_1000, 16'd4, 16'd4, 0, 1'b0,
                    '{32'h1000, 32'h1004, 32'h1008, 32'h100C}, 4, 4};
        jobs[1] = '{32'h0000_1000, 16'd4, 16'd4, 1, 1'b0,
                    '{32'h1000, 32'h1004, 32'h1008, 32'h100C}, 4, 8};
        jobs[2] = '{32'hFFFF_FFF8, 16'd8, 16'd3, 0, 1'b0,
                    '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 32'h0}, 3, 3};
        jobs[3] = '{32'h0000_7777, 16'd4, 16'd0, 0, 1'b0,
                    '{32'h0, 32'h0, 32'h0, 32'h0}, 0, 0};
        jobs[4] = '{32'h0000_0500, 16'h10, 16'd2, 2, 1'b0,
                    '{32'h500, 32'h510, 32'h0, 32'h0}, 2, 4};
        jobs[5] = '{32'h0000_1000, 16'd4, 16'd4, 0, 1'b1,
                    '{32'h1000, 32'h1004, 32'h1008, 32'h100C}, 4, 4};
        jobs[6] = '{32'h0000_0040, 16'd0, 16'd1, 0, 1'b0,
                    '{32'h40, 32'h0, 32'h0, 32'h0}, 1, 1};

        // Reset state: with valid and gnt high, every output stays quiet.
        stream_valid_i = 1'b1;
        tcdm_gnt_i     = 1'b1;
        stream_strb_i  = 4'hA;
        stream_data_i  = 32'h1234_5678;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst req", 32'(tcdm_req_o), 32'd0);
        chk("rst ready", 32'(stream_ready_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst add", tcdm_add_o, 32'd0);
        chk("rst wen", 32'(tcdm_wen_o), 32'd0);
        chk("rst be", 32'(tcdm_be_o), 32'hA);
        chk("rst data", tcdm_data_o, 32'h1234_5678);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 7; i++) begin
            run_job(jobs[i], $sformatf("job%0d", i));
            @(posedge clk_i); #1;
        end

        // Clear after 2 of 8 handshakes: abort with no done pulse, then restart cleanly.
        begin
            job_t j8, jr;
            j8 = '{32'h0000_3000, 16'd4, 16'd8, 0, 1'b0,
                   '{32'h3000, 32'h3004, 32'h3008, 32'h300C}, 0, 0};
            start_i = 1'b1; base_addr_i = j8.base; stride_i = j8.stride; num_words_i = j8.num;
            stream_valid_i = 1'b1; tcdm_gnt_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk_i);
                chk("clr pre_add", tcdm_add_o, j8.exp_addr[c]);
                chk("clr pre_busy", 32'(busy_o), 32'd1);
                @(posedge clk_i); #1;
            end
            clear_i = 1'b1;
            @(posedge clk_i); #1;
            clear_i = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                chk("clr req", 32'(tcdm_req_o), 32'd0);
                chk("clr ready", 32'(stream_ready_o), 32'd0);
                chk("clr busy", 32'(busy_o), 32'd0);
                chk("clr done", 32'(done_o), 32'd0);
                @(posedge clk_i); #1;
            end
            jr = '{32'h0000_2000, 16'd4, 16'd2, 0, 1'b0,
                   '{32'h2000, 32'h2004, 32'h0, 32'h0}, 2, 2};
            run_job(jr, "restart");
            @(posedge clk_i); #1;

            // Reset mid-job behaves like clear.
            start_i = 1'b1; base_addr_i = 32'h4000; stride_i = 16'd4; num_words_i = 16'd5;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            @(negedge clk_i);
            chk("rstmid pre_add", tcdm_add_o, 32'h4000);
            @(posedge clk_i); #1;
            rst_ni = 1'b0;
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
            @(negedge clk_i);
            chk("rstmid req", 32'(tcdm_req_o), 32'd0);
            chk("rstmid busy", 32'(busy_o), 32'd0);
            chk("rstmid done", 32'(done_o), 32'd0);
            chk("rstmid add", tcdm_add_o, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
